// File: rtl/edge_generator_pkg.sv
// ============================================================================
//  Module      : edge_generator_pkg
//  Description : Shared state encoding and default widths for edge_generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_generator_pkg;

  // Default width of the length and count fields
  localparam int CNT_W_DEFAULT = 8;

  // Generator states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/edge_generator_counter.sv
// ============================================================================
//  Module      : load_down_counter
//  Description : Loadable down counter; expire flags the final counted cycle
//                (count == 1 while enabled). Never wraps below zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_down_counter
  import edge_generator_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins over decrement; saturate at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = en && (count_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/edge_generator.sv
// ============================================================================
//  Module      : edge_generator
//  Description : Programmable pulse-burst generator. Accepts a command over
//                valid/ready and drives N pulses of H high / L low cycles with
//                registered rise/fall strobes and a completion strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_generator
  import edge_generator_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_high_len,
  input  logic [CNT_W-1:0] req_low_len,
  input  logic [CNT_W-1:0] req_count,
  input  logic             abort,
  output logic             out,
  output logic             r_edge,
  output logic             f_edge,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] l_q, l_d;
  logic             out_q, out_d;
  logic             r_edge_q, r_edge_d;
  logic             f_edge_q, f_edge_d;
  logic             done_q, done_d;

  logic             phase_load;
  logic [CNT_W-1:0] phase_load_val;
  logic             phase_en;
  logic             phase_exp;
  logic [CNT_W-1:0] phase_cnt;
  logic             pulse_load;
  logic             pulse_en;
  logic             pulse_exp;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] h_eff;
  logic [CNT_W-1:0] l_eff;

  // Zero-length phases are stretched to one cycle
  assign h_eff = (req_high_len == '0) ? CNT_W'(1) : req_high_len;
  assign l_eff = (req_low_len  == '0) ? CNT_W'(1) : req_low_len;

  // Cycles remaining in the current high/low phase
  load_down_counter #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (phase_load),
    .load_val (phase_load_val),
    .en       (phase_en),
    .count    (phase_cnt),
    .expire   (phase_exp)
  );

  // Pulses remaining in the burst, stepped at the end of each low phase
  load_down_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pulse_load),
    .load_val (req_count),
    .en       (pulse_en),
    .count    (pulse_cnt),
    .expire   (pulse_exp)
  );

  // Sequencing only looks at expiry; raw counts are not needed here
  logic unused_counts;
  assign unused_counts = ^{phase_cnt, pulse_cnt};

  // Next-state and registered-output logic; abort outranks phase expiry
  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    l_d            = l_q;
    out_d          = out_q;
    r_edge_d       = 1'b0;
    f_edge_d       = 1'b0;
    done_d         = 1'b0;
    phase_load     = 1'b0;
    phase_load_val = h_q;
    phase_en       = 1'b0;
    pulse_load     = 1'b0;
    pulse_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          h_d = h_eff;
          l_d = l_eff;
          if (req_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d        = HIGH;
            out_d          = 1'b1;
            r_edge_d       = 1'b1;
            phase_load     = 1'b1;
            phase_load_val = h_eff;
            pulse_load     = 1'b1;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_d  = IDLE;
          out_d    = 1'b0;
          f_edge_d = out_q;
          done_d   = 1'b1;
        end else begin
          phase_en = 1'b1;
          if (phase_exp) begin
            state_d        = LOW;
            out_d          = 1'b0;
            f_edge_d       = 1'b1;
            phase_load     = 1'b1;
            phase_load_val = l_q;
          end
        end
      end

      LOW: begin
        if (abort) begin
          state_d  = IDLE;
          out_d    = 1'b0;
          f_edge_d = out_q;
          done_d   = 1'b1;
        end else begin
          phase_en = 1'b1;
          pulse_en = phase_exp;
          if (phase_exp) begin
            if (pulse_exp) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d        = HIGH;
              out_d          = 1'b1;
              r_edge_d       = 1'b1;
              phase_load     = 1'b1;
              phase_load_val = h_q;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
      end
    endcase
  end

  // State, latched lengths and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      h_q      <= '0;
      l_q      <= '0;
      out_q    <= 1'b0;
      r_edge_q <= 1'b0;
      f_edge_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      l_q      <= l_d;
      out_q    <= out_d;
      r_edge_q <= r_edge_d;
      f_edge_q <= f_edge_d;
      done_q   <= done_d;
    end
  end

  assign out       = out_q;
  assign r_edge    = r_edge_q;
  assign f_edge    = f_edge_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_edge_generator.sv
// ============================================================================
//  Module      : tb_edge_generator
//  Description : Directed self-checking bench for edge_generator. Each burst
//                is captured cycle by cycle into bit vectors (bit k-1 holds
//                cycle T+k after the accept cycle T) and compared against
//                hand-derived waveforms.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_generator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_high_len = '0;
  logic [W-1:0] req_low_len = '0;
  logic [W-1:0] req_count = '0;
  logic         abort = 1'b0;
  logic         out_w;
  logic         r_edge;
  logic         f_edge;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] v_out, v_r, v_f, v_d, v_b, v_rdy;
  logic [W-1:0] nx_h = '0, nx_l = '0, nx_n = '0;

  always #5 clk = ~clk;

  edge_generator #(.CNT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_high_len (req_high_len),
    .req_low_len  (req_low_len),
    .req_count    (req_count),
    .abort        (abort),
    .out          (out_w),
    .r_edge       (r_edge),
    .f_edge       (f_edge),
    .busy         (busy),
    .done         (done)
  );

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present a command; the following posedge is the accept cycle T
  task automatic send(input logic [W-1:0] h, input logic [W-1:0] l, input logic [W-1:0] n);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_send", 32'(req_ready), 32'd1);
    req_high_len = h;
    req_low_len  = l;
    req_count    = n;
    req_valid    = 1'b1;
    @(posedge clk);
  endtask

  // Capture ncyc cycles; abort/rst are pulsed in cycle abort_at/rst_at,
  // req_valid is held through cycle valid_until-1.
  task automatic run(input int ncyc, input int abort_at, input int rst_at, input int valid_until);
    v_out = '0; v_r = '0; v_f = '0; v_d = '0; v_b = '0; v_rdy = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      v_out[k-1] = out_w;
      v_r[k-1]   = r_edge;
      v_f[k-1]   = f_edge;
      v_d[k-1]   = done;
      v_b[k-1]   = busy;
      v_rdy[k-1] = req_ready;
      abort      = (k == abort_at);
      rst        = (k == rst_at);
      if (k == 1 && valid_until > 1) begin
        req_high_len = nx_h;
        req_low_len  = nx_l;
        req_count    = nx_n;
      end
      req_valid = (k < valid_until);
    end
    abort     = 1'b0;
    rst       = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset then idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(20, 0, 0, 1);
    check("idle_out",    v_out, 32'h0);
    check("idle_strobe", v_r | v_f | v_d, 32'h0);
    check("idle_busy",   v_b, 32'h0);
    check("idle_ready",  v_rdy, 32'h000F_FFFF);

    // Single burst H=2 L=3 N=2
    send(8'd2, 8'd3, 8'd2);
    run(12, 0, 0, 1);
    check("burst_out",   v_out, 32'b0000_0110_0011);
    check("burst_r",     v_r,   32'b0000_0010_0001);
    check("burst_f",     v_f,   32'b0000_1000_0100);
    check("burst_done",  v_d,   32'b0100_0000_0000);
    check("burst_busy",  v_b,   32'b0011_1111_1111);
    check("burst_ready", v_rdy, 32'b1100_0000_0000);

    // Zero lengths: H=0 L=0 N=3
    send(8'd0, 8'd0, 8'd3);
    run(8, 0, 0, 1);
    check("zlen_out",  v_out, 32'b0001_0101);
    check("zlen_r",    v_r,   32'b0001_0101);
    check("zlen_f",    v_f,   32'b0010_1010);
    check("zlen_done", v_d,   32'b0100_0000);
    check("zlen_busy", v_b,   32'b0011_1111);

    // Empty burst N=0
    send(8'd4, 8'd4, 8'd0);
    run(4, 0, 0, 1);
    check("empty_out",   v_out | v_r | v_f, 32'h0);
    check("empty_done",  v_d,   32'b0001);
    check("empty_busy",  v_b,   32'h0);
    check("empty_ready", v_rdy, 32'b1111);

    // Abort during high phase: H=5 L=5 N=4, abort in T+3
    send(8'd5, 8'd5, 8'd4);
    run(6, 3, 0, 1);
    check("abort_out",   v_out, 32'b00_0111);
    check("abort_r",     v_r,   32'b00_0001);
    check("abort_f",     v_f,   32'b00_1000);
    check("abort_done",  v_d,   32'b00_1000);
    check("abort_busy",  v_b,   32'b00_0111);
    check("abort_ready", v_rdy, 32'b11_1000);

    // Abort while idle has no effect
    run(4, 2, 0, 1);
    check("idle_abort_strobes", v_out | v_r | v_f | v_d, 32'h0);
    check("idle_abort_busy",    v_b, 32'h0);

    // Back-to-back with req_valid held; fields change while busy
    nx_h = 8'd2; nx_l = 8'd1; nx_n = 8'd1;
    send(8'd1, 8'd1, 8'd1);
    run(8, 0, 0, 4);
    check("b2b_out",  v_out, 32'b0001_1001);
    check("b2b_r",    v_r,   32'b0000_1001);
    check("b2b_f",    v_f,   32'b0010_0010);
    check("b2b_done", v_d,   32'b0100_0100);
    check("b2b_busy", v_b,   32'b0011_1011);

    // Reset during a long high phase: H=10 N=1, rst in T+4
    send(8'd10, 8'd1, 8'd1);
    run(8, 0, 4, 1);
    check("rstmid_out",   v_out, 32'b0000_1111);
    check("rstmid_r",     v_r,   32'b0000_0001);
    check("rstmid_fd",    v_f | v_d, 32'h0);
    check("rstmid_busy",  v_b,   32'b0000_1111);
    check("rstmid_ready", v_rdy, 32'b1111_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
